// File: rtl/lut3_sweep_ctrl.sv
// Sweeps all 8 input vectors of a 3-input logic block, captures its truth table through a synchronizer.
// Optional compare against the expected rule is built when LUT3_SWEEP_COMPARE_EN is defined.
module lut3_sweep_ctrl #(
   parameter int SETTLE_W    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [7:0]          rule,
   input  logic [SETTLE_W-1:0] settle,
   output logic [2:0]          dut_in,
   input  logic                dut_out,
   output logic                busy,
   output logic                done,
   output logic [7:0]          table_out,
   output logic                mismatch,
   output logic [7:0]          mismatch_mask
);

   localparam int CNT_W = SETTLE_W + 2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_APPLY  = 3'd1,
      S_WAIT   = 3'd2,
      S_SAMPLE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [2:0]          idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic [7:0]          cap_q, cap_d;
   logic [7:0]          tab_q, tab_d;
   logic [7:0]          cap_new;
   logic                sync_out;

`ifdef LUT3_SWEEP_COMPARE_EN
   logic [7:0] rule_q, rule_d;
   logic [7:0] mask_q, mask_d;
   logic       mism_q, mism_d;
`endif

   assign sync_out = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         sync_q   <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         settle_q <= '0;
         cap_q    <= '0;
         tab_q    <= '0;
`ifdef LUT3_SWEEP_COMPARE_EN
         rule_q   <= '0;
         mask_q   <= '0;
         mism_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sync_q   <= {sync_q[SYNC_STAGES-2:0], dut_out};
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         settle_q <= settle_d;
         cap_q    <= cap_d;
         tab_q    <= tab_d;
`ifdef LUT3_SWEEP_COMPARE_EN
         rule_q   <= rule_d;
         mask_q   <= mask_d;
         mism_q   <= mism_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      settle_d = settle_q;
      cap_d    = cap_q;
      tab_d    = tab_q;
      cap_new  = cap_q;
      cap_new[3'd7 - idx_q] = sync_out;
`ifdef LUT3_SWEEP_COMPARE_EN
      rule_d   = rule_q;
      mask_d   = mask_q;
      mism_d   = mism_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d  = S_APPLY;
               settle_d = settle;
               cap_d    = '0;
               idx_d    = '0;
`ifdef LUT3_SWEEP_COMPARE_EN
               rule_d   = rule;
`endif
            end
         end
         S_APPLY: begin
            if (abort) begin
               state_d = S_IDLE;
               cap_d   = '0;
            end else begin
               cnt_d   = CNT_W'(settle_q) + CNT_W'(SYNC_STAGES);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (abort) begin
               state_d = S_IDLE;
               cap_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_SAMPLE: begin
            // Result registers load here so they are already valid while done is high.
            if (abort) begin
               state_d = S_IDLE;
               cap_d   = '0;
            end else begin
               cap_d = cap_new;
               if (idx_q == 3'd7) begin
                  state_d = S_DONE;
                  tab_d   = cap_new;
`ifdef LUT3_SWEEP_COMPARE_EN
                  mask_d  = cap_new ^ rule_q;
                  mism_d  = |(cap_new ^ rule_q);
`endif
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = S_APPLY;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign dut_in    = (state_q == S_APPLY || state_q == S_WAIT || state_q == S_SAMPLE) ? idx_q : 3'b000;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign table_out = tab_q;

`ifdef LUT3_SWEEP_COMPARE_EN
   assign mismatch      = mism_q;
   assign mismatch_mask = mask_q;
`else
   logic unused_rule;
   assign unused_rule   = ^rule;
   assign mismatch      = 1'b0;
   assign mismatch_mask = 8'h00;
`endif

endmodule

// File: tb/tb_lut3_sweep_ctrl.sv
// Scoreboard bench for lut3_sweep_ctrl: stimulus pushes expected sweep results, a monitor checks each done.
// Expectations follow LUT3_SWEEP_COMPARE_EN the same way the design build does.
module tb_lut3_sweep_ctrl;

   localparam int SW = 8;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [7:0]    rule = 8'h00;
   logic [SW-1:0] settle = '0;
   logic [2:0]    dut_in;
   logic          dut_out;
   logic          busy, done, mismatch;
   logic [7:0]    table_out, mismatch_mask;
   logic [7:0]    model_tab = 8'h00;

   lut3_sweep_ctrl #(.SETTLE_W(SW), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .rule(rule), .settle(settle),
      .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .table_out(table_out),
      .mismatch(mismatch), .mismatch_mask(mismatch_mask)
   );

   // Block under test: output for vector v lives in bit (7-v) of its truth table.
   assign dut_out = model_tab[3'd7 - dut_in];

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] tab;
      logic [7:0] mask;
      logic       mism;
      int         due;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   st_cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] r, input logic [7:0] tab, input int due);
      exp_t e;
      e.tab = tab;
`ifdef LUT3_SWEEP_COMPARE_EN
      e.mask = tab ^ r;
      e.mism = |(tab ^ r);
`else
      e.mask = 8'h00;
      e.mism = 1'b0;
`endif
      e.due = due;
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", {31'd0, done}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("table_out", {24'd0, table_out}, {24'd0, mon_e.tab});
            chk("mismatch_mask", {24'd0, mismatch_mask}, {24'd0, mon_e.mask});
            chk("mismatch", {31'd0, mismatch}, {31'd0, mon_e.mism});
            chk("done_cycle", cyc, mon_e.due);
         end
      end
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_sweep(input logic [7:0] r, input logic [SW-1:0] s, input logic [7:0] tab, input bit push);
      model_tab = tab;
      rule      = r;
      settle    = s;
      start     = 1'b1;
      st_cyc    = cyc;
      if (push) exp_q.push_back(mk(r, tab, st_cyc + 8 * (int'(s) + SS + 3) + 1));
      @(posedge clk);
      #1;
      start  = 1'b0;
      rule   = 8'($urandom);
      settle = SW'($urandom);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("timeout_pending", exp_q.size(), 32'd0);
         exp_q.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_table"}, {24'd0, table_out}, 32'd0);
      chk({tag, "_mism"}, {31'd0, mismatch}, 32'd0);
      chk({tag, "_mask"}, {24'd0, mismatch_mask}, 32'd0);
      chk({tag, "_dut_in"}, {29'd0, dut_in}, 32'd0);
   endtask

   initial begin
      logic [7:0] r, tab;
      logic [SW-1:0] s;

      #12;
      chk_all_zero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Nominal sweep
      start_sweep(8'h3D, 0, 8'h3D, 1'b1);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      drain(500);

      // Faulty block: vector 110 stuck at 1
      start_sweep(8'h3D, 3, 8'h3F, 1'b1);
      drain(500);

      // Abort during WAIT of vector 4 (period 7 with settle 2)
      start_sweep(8'hA5, 2, 8'hA5, 1'b0);
      wait_cyc(st_cyc + 4 * 7 + 2);
      chk("abort_vec", {29'd0, dut_in}, 32'd4);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      repeat (80) @(posedge clk);
      #1;
      chk("abort_table_held", {24'd0, table_out}, 32'h3F);

      // Start pulse while busy must be ignored
      start_sweep(8'h5A, 1, 8'h5A, 1'b1);
      wait_cyc(st_cyc + 10);
      start = 1'b1;
      rule  = 8'hFF;
      @(posedge clk);
      #1;
      start = 1'b0;
      drain(500);
      repeat (60) @(posedge clk);
      #1;

      // Asynchronous reset during vector 5 (period 5 with settle 0)
      start_sweep(8'h11, 0, 8'h11, 1'b0);
      wait_cyc(st_cyc + 5 * 5 + 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      start_sweep(8'h96, 1, 8'h96, 1'b1);
      drain(500);

      // Randomized sweeps, including maximum settle
      for (int i = 0; i < 8; i++) begin
         r   = 8'($urandom);
         s   = (i == 0) ? SW'(255) : SW'($urandom_range(0, 4));
         tab = ($urandom_range(0, 1) == 1) ? r : (r ^ 8'(1 << $urandom_range(0, 7)));
         start_sweep(r, s, tab, 1'b1);
         drain(3000);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lut3_sweep_ctrl.md
LUT3_SWEEP_CTRL -- requirements
Module: lut3_sweep_ctrl

Interface
REQ-001 Parameter: SETTLE_W, 8, width of settle-time count.
REQ-002 Parameter: SYNC_STAGES, 2, flops in the dut_out synchronizer (minimum 2).
REQ-003 clk  input  1  single clock; all flops rise-edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request one sweep; sampled only in IDLE.
REQ-006 abort  input  1  cancel the sweep in progress.
REQ-007 rule  input  8  expected truth-table code, latched at accepted start.
REQ-008 settle  input  SETTLE_W  extra wait cycles per vector, latched at accepted start.
REQ-009 dut_in  output  3  drives {in1,in2,in3} of the 3-input logic block under test.
REQ-010 dut_out  input  1  block output; asynchronous to clk.
REQ-011 busy  output  1  high from the cycle after an accepted start until DONE is left.
REQ-012 done  output  1  one-cycle pulse when a sweep completes.
REQ-013 table_out  output  8  captured truth table.
REQ-014 mismatch  output  1  captured table differs from rule.
REQ-015 mismatch_mask  output  8  per-row difference.

Function
REQ-016 Table bit convention: the output for input vector v = {in1,in2,in3} is held in bit (7-v) (000 -> bit7, 111 -> bit0).
REQ-017 dut_out passes through a SYNC_STAGES flop synchronizer before any use.
REQ-018 FSM states: IDLE, APPLY, WAIT, SAMPLE, DONE.
REQ-019 IDLE: dut_in=000; start=1 with abort=0 latches rule and settle, clears the capture register, sets the vector index to 0, and enters APPLY.
REQ-020 APPLY: 1 cycle; dut_in = vector index; loads the wait counter with settle+SYNC_STAGES; enters WAIT.
REQ-021 WAIT: decrements the counter each cycle; dut_in is held; enters SAMPLE in the cycle after the counter reads 0 (settle+SYNC_STAGES+1 cycles in WAIT).
REQ-022 SAMPLE: 1 cycle; writes the synchronized dut_out into capture bit (7-index); index 7 enters DONE, otherwise the index increments and the FSM enters APPLY.
REQ-023 Per-vector time: settle+SYNC_STAGES+3 cycles; sweep from the start cycle to the done pulse is 8*(settle+SYNC_STAGES+3)+1 cycles.
REQ-024 DONE: 1 cycle; done=1; table_out and the mismatch outputs update in this same cycle; returns to IDLE.
REQ-025 table_out, mismatch and mismatch_mask hold their values until the next DONE.
REQ-026 start outside IDLE is ignored and is not queued.
REQ-027 abort in APPLY, WAIT or SAMPLE returns the FSM to IDLE on the next edge: no done, outputs keep their previous values, and the partial capture is discarded.
REQ-028 abort and start together in IDLE: abort wins and no sweep starts.
REQ-029 settle = 0 is legal; settle at its maximum value must not overflow the counter (the counter width is SETTLE_W+2).

Reset
REQ-030 rst_n low asynchronously forces: IDLE, dut_in=000, busy=0, done=0, table_out=0, mismatch=0, mismatch_mask=0, synchronizer=0, counter=0, index=0.
REQ-031 Reset mid-sweep abandons the sweep with no done pulse; the first start accepted after release begins a fresh sweep.

Configuration
REQ-032 Macro LUT3_SWEEP_COMPARE_EN defined: at DONE, mismatch_mask = capture XOR latched rule and mismatch = OR-reduce of the mask.
REQ-033 Macro LUT3_SWEEP_COMPARE_EN undefined:
- no comparison logic is built;
- mismatch and mismatch_mask are constant 0;
- rule is not latched;
- all other behaviour is unchanged.

Verification
REQ-034 Test 1 (nominal):
- Stimulus: rule=0x3D, settle=0, dut_out driven combinationally by a rule-0x3D model of dut_in.
- Response: done after 8*(0+2+3)+1=41 cycles, table_out=0x3D, mismatch=0 (macro on).
REQ-035 Test 2 (fault detection):
- Stimulus: rule=0x3D, model forced to output 1 for vector 110, settle=3.
- Response: table_out=0x3F, mismatch_mask=0x02, mismatch=1, done at cycle 8*8+1=65.
REQ-036 Test 3 (abort): start a sweep, assert abort during WAIT of vector 4 -> busy=0 next cycle, no done, table_out still holds the previous sweep value.
REQ-037 Test 4 (start while busy): pulse start at sweep cycle 10 with rule=0xFF -> ignored; the sweep completes with the original rule, and exactly one done is observed.
REQ-038 Test 5 (reset mid-sweep): assert rst_n=0 asynchronously during vector 5 -> all outputs are 0 immediately; after release, start with rule=0x96 and a matching model -> table_out=0x96.
REQ-039 Test 6 (build without LUT3_SWEEP_COMPARE_EN): repeat Test 2 -> table_out=0x3F, mismatch=0, mismatch_mask=0x00.
